// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  dm_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, mem_read, mem_write, dm_ctrl, addr, wdata,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, dm_ctrl, addr, wdata,
    output req_ready, rsp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency byte/half/word loads and stores on a
// word-addressed RAM. Define DMEM_STATS_EN to add load/store/error counters.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rstn,
  dmem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rd_q, rd_d, wr_q, wr_d, bad_q, bad_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [1:0]      lane_q, lane_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  logic            accept, req_bad, commit, mem_we;
  logic [31:0]     word_rd, load_val, st_data;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [3:0]      st_be;
  logic            unused_addr;

  assign unused_addr   = ^bus.addr[31:AW+2];
  assign bus.req_ready = (state_q != BUSY);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

  assign accept = bus.req_ready & bus.req_valid & (bus.mem_read | bus.mem_write);
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we = commit & wr_q & ~bad_q;

  // Legality is decided at acceptance; the flag rides along to the commit edge.
  always_comb begin
    req_bad = bus.mem_read & bus.mem_write;
    case (bus.dm_ctrl)
      3'b000:         req_bad = req_bad | (bus.addr[1:0] != 2'b00);
      3'b001, 3'b010: req_bad = req_bad | bus.addr[0];
      3'b011, 3'b100: req_bad = req_bad;
      default:        req_bad = 1'b1;
    endcase
  end

  assign word_rd  = mem[idx_q];
  assign byte_sel = word_rd[{lane_q, 3'b000} +: 8];
  assign half_sel = lane_q[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    load_val = 32'd0;
    st_data  = wdata_q;
    st_be    = 4'b1111;
    case (ctrl_q)
      3'b000: load_val = word_rd;
      3'b001: load_val = {{16{half_sel[15]}}, half_sel};
      3'b010: load_val = {16'd0, half_sel};
      3'b011: load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_val = {24'd0, byte_sel};
      default: load_val = 32'd0;
    endcase
    if (ctrl_q == 3'b001 || ctrl_q == 3'b010) begin
      st_data = {2{wdata_q[15:0]}};
      st_be   = lane_q[1] ? 4'b1100 : 4'b0011;
    end else if (ctrl_q == 3'b011 || ctrl_q == 3'b100) begin
      st_data = {4{wdata_q[7:0]}};
      st_be   = 4'b0001 << lane_q;
    end
  end

  // RAM has no reset so it maps onto block RAM; untouched lanes keep their bytes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx_q][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    ctrl_d  = ctrl_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          rd_d    = bus.mem_read;
          wr_d    = bus.mem_write;
          bad_d   = req_bad;
          ctrl_d  = bus.dm_ctrl;
          lane_d  = bus.addr[1:0];
          idx_d   = bus.addr[AW+1:2];
          wdata_d = bus.wdata;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          err_d   = bad_q;
          rdata_d = (bad_q || wr_q) ? 32'd0 : load_val;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      ctrl_q  <= 3'd0;
      lane_q  <= 2'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      ctrl_q  <= ctrl_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;

  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == RESP) begin
      if (err_q)     stat_errs_d   = stat_errs_q + 32'd1;
      else if (wr_q) stat_stores_d = stat_stores_q + 32'd1;
      else           stat_loads_d  = stat_loads_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_loads_q  <= 32'd0;
      stat_stores_q <= 32'd0;
      stat_errs_q   <= 32'd0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed load/store/error/reset cases
// followed by randomized traffic checked against a byte-array memory model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int BYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef DMEM_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model [BYTES];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          n_push = 0;
  int          n_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: memory as a flat byte array, access size from the width code.
  function automatic void ref_model(input logic rd, input logic wr, input logic [2:0] ctrl,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] rdata, output logic err);
    int size;
    int base;
    logic [31:0] v;
    size = (ctrl == 3'd0) ? 4 : (ctrl <= 3'd2) ? 2 : (ctrl <= 3'd4) ? 1 : 0;
    base = int'(a % BYTES);
    rdata = 32'd0;
    err = 1'b0;
    if ((rd && wr) || size == 0 || (base % size) != 0) begin
      err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < size; i++) model[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = model[base + i];
      if ((ctrl == 3'd1 || ctrl == 3'd3) && v[8*size-1])
        v = v | ~((32'd1 << (8*size)) - 32'd1);
      rdata = v;
    end
  endfunction

  task automatic do_req(input logic rd, input logic wr, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] wd, input bit expect_rsp);
    bit ok;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.dm_ctrl   = ctrl;
    bus.addr      = a;
    bus.wdata     = wd;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got req_ready=0 for 40 cycles required 1");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (expect_rsp) begin
      ref_model(rd, wr, ctrl, a, wd, e.rdata, e.err);
      e.acc = cyc;
      exp_q.push_back(e);
      n_push++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending responses required 0", exp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rstn && bus.rsp_valid === 1'b1) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h required no response", bus.rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] rsp %0d rdata=%h err=%b (expect %h/%b)", n_rsp, bus.rdata, bus.err, e.rdata, e.err);
        check("rsp_rdata", bus.rdata, e.rdata);
        check("rsp_err", {31'd0, bus.err}, {31'd0, e.err});
        check("rsp_latency", 32'(cyc), 32'(e.acc + LAT));
      end
    end
  end

  initial begin
    int a1;
    int op;
    logic [2:0] ctrl;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.dm_ctrl   = 3'd0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;

    // Word store/load, with busy-phase ready check
    do_req(1'b0, 1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
    do_req(1'b1, 1'b0, 3'd0, 32'h10, 32'h0, 1'b1);
    idle();

    // Sub-word stores and extension
    do_req(1'b0, 1'b1, 3'd0, 32'h20, 32'h00000000, 1'b1);
    do_req(1'b0, 1'b1, 3'd4, 32'h21, 32'h00000080, 1'b1);
    do_req(1'b0, 1'b1, 3'd2, 32'h22, 32'h0000F00D, 1'b1);
    do_req(1'b1, 1'b0, 3'd0, 32'h20, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 3'd3, 32'h21, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 3'd4, 32'h21, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 3'd2, 32'h22, 32'h0, 1'b1);
    idle();

    // Illegal requests leave memory untouched
    do_req(1'b0, 1'b1, 3'd0, 32'h30, 32'hA5A55A5A, 1'b1);
    do_req(1'b0, 1'b1, 3'd1, 32'h31, 32'hFFFFFFFF, 1'b1);
    do_req(1'b1, 1'b0, 3'd0, 32'h32, 32'h0, 1'b1);
    do_req(1'b0, 1'b1, 3'd6, 32'h30, 32'h11111111, 1'b1);
    do_req(1'b1, 1'b1, 3'd0, 32'h30, 32'h22222222, 1'b1);
    do_req(1'b1, 1'b0, 3'd0, 32'h30, 32'h0, 1'b1);
    idle();
    drain();

    // Back-to-back: second request taken in the RESP cycle
    do_req(1'b0, 1'b1, 3'd0, 32'h50, 32'h0BADCAFE, 1'b1);
    a1 = last_acc;
    do_req(1'b1, 1'b0, 3'd0, 32'h50, 32'h0, 1'b1);
    check("b2b_accept_cycle", 32'(last_acc), 32'(a1 + LAT + 1));
    idle();

    // Address wrap modulo 4*DEPTH
    do_req(1'b0, 1'b1, 3'd0, 32'h1000, 32'hCAFEF00D, 1'b1);
    do_req(1'b1, 1'b0, 3'd0, 32'h0000, 32'h0, 1'b1);
    idle();
    drain();

    // Reset before commit aborts the store
    do_req(1'b0, 1'b1, 3'd0, 32'h40, 32'h11112222, 1'b1);
    idle();
    drain();
    do_req(1'b0, 1'b1, 3'd0, 32'h40, 32'h12345678, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_idle_outputs("midop");
`ifdef DMEM_STATS_EN
    check("stat_loads_zero", stat_loads, 32'd0);
    check("stat_stores_zero", stat_stores, 32'd0);
    check("stat_errs_zero", stat_errs, 32'd0);
`endif
    repeat (4) @(negedge clk);
    do_req(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 1'b1);
    idle();

    // Valid without read/write is ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    drain();
    @(negedge clk);
    check("nonreq_ready", {31'd0, bus.req_ready}, 32'd1);
    idle();

    // Randomized traffic over a pre-initialised window
    for (int w = 0; w < 16; w++)
      do_req(1'b0, 1'b1, 3'd0, 32'h100 + 32'(4*w), $urandom, 1'b1);
    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 7));
      ctrl = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      a = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
      if (op <= 2)      do_req(1'b1, 1'b0, ctrl, a, $urandom, 1'b1);
      else if (op <= 5) do_req(1'b0, 1'b1, ctrl, a, $urandom, 1'b1);
      else if (op == 6) do_req(1'b1, 1'b1, ctrl, a, $urandom, 1'b1);
      else begin
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    drain();
    repeat (3) @(negedge clk);
    check("rsp_count", 32'(n_rsp), 32'(n_push));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
